// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding,
// slice width and the nibble-index width helper.
package nibble_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // Width of the nibble index: enough bits to count NIB steps, never zero.
    function automatic int idx_w(input int nib);
        int w;
        w = $clog2(nib);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
// The sub line exists only when NIBBLE_SERIAL_SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    // Producer/consumer side
    modport master (
        output in_valid, a, b, cin,
`ifdef NIBBLE_SERIAL_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin,
`ifdef NIBBLE_SERIAL_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_add_ctrl_slice.sv
// nibble_rca_slice: combinational 4-bit ripple-carry adder built from a
// chain of full-adder cells.
module nibble_rca_slice
    import nibble_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_cout
);
    logic [NIB_W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < NIB_W; g++) begin : g_fa
        assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]   = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[NIB_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add done one nibble per clock through a
// single 4-bit slice, LS nibble first, with valid/ready on both sides.
// Optional subtract mode under NIBBLE_SERIAL_SUB_EN (a - b, cout=1 = no borrow).
module nibble_serial_add_ctrl
    import nibble_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_add_ctrl_if.slave  bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = idx_w(NIB);

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic [NIB_W-1:0]   w_a_nib;
    logic [NIB_W-1:0]   w_b_nib;
    logic [NIB_W-1:0]   w_s_nib;
    logic               w_s_cout;
    logic               w_carry_init;

`ifdef NIBBLE_SERIAL_SUB_EN
    logic               r_sub;
    // Subtract is a + ~b + 1, so the b nibble is inverted and carry starts at 1
    assign w_b_nib      = r_sub ? ~r_b[4*r_idx +: 4] : r_b[4*r_idx +: 4];
    assign w_carry_init = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_b_nib      = r_b[4*r_idx +: 4];
    assign w_carry_init = bus.cin;
`endif

    assign w_a_nib  = r_a[4*r_idx +: 4];
    assign w_last   = (r_idx == IDX_W'(NIB - 1));
    assign w_accept = bus.in_valid & w_in_ready;

    nibble_rca_slice u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_s_nib),
        .o_cout (w_s_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and state-decoded handshake outputs (no in_valid/out_ready to output path)
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, per-nibble sum assembly and carry chaining
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= w_carry_init;
                        r_idx   <= '0;
                        r_sum   <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
                        r_sub   <= bus.sub;
`endif
                    end
                end
                RUN: begin
                    r_sum[4*r_idx +: 4] <= w_s_nib;
                    r_carry             <= w_s_cout;
                    if (w_last) begin
                        r_cout <= w_s_cout;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule
